// File: rtl/mac_frame_collector.sv
// mac_frame_collector
//
// Purpose:
//   Watches a 64-bit / 8-lane control+data receive stream (lane 0 is first in
//   time), finds the start control word and packs every frame byte from START
//   through TERM (inclusive) into a flat little-endian byte array. A completed
//   frame is copied to the output register together with its byte length and
//   announced with a one-cycle o_frame_valid pulse. Aborted frames raise
//   o_frame_error and oversize frames raise o_overflow. Neither of these
//   touches the output register.
//
// Ports:
//   clk            clock
//   i_rst_n        asynchronous active-low reset
//   i_rx_data      receive word, lane k = i_rx_data[8k+:8]
//   i_rx_ctrl      bit k = 1 marks lane k as a control character
//   i_rx_valid     word qualifier
//   o_frame_data   frame byte n at [8n+:8], byte 0 = START_CODE, zero past length
//   o_frame_len    frame length in bytes, START and TERM included
//   o_frame_valid  one-cycle pulse, o_frame_data/o_frame_len just updated
//   o_frame_error  one-cycle pulse, frame aborted (bad control or restart)
//   o_overflow     one-cycle pulse, frame exceeded MAX_FRAME_BYTES
//   o_frame_count  good frames delivered (wraps)
//   o_dbg_state    current FSM state (IDLE=0, COLLECT=1, DROP=2)
//
// Handshake: a word is consumed on a rising clk edge only when i_rx_valid=1.
// There is no backpressure. When i_rx_valid=0, all state holds and the pulses
// drop to 0 on that edge. The pulses are registered, so they are high for the
// cycle that follows the edge that consumed the causing word.

module mac_frame_collector #(
    parameter int          DATA_WIDTH      = 64,
    parameter int          CTRL_WIDTH      = 8,
    parameter int          MAX_FRAME_BYTES = 1527,
    parameter logic [7:0]  IDLE_CODE       = 8'h07,
    parameter logic [7:0]  START_CODE      = 8'hFB,
    parameter logic [7:0]  TERM_CODE       = 8'hFD
) (
    input  logic                         clk,
    input  logic                         i_rst_n,
    input  logic [DATA_WIDTH-1:0]        i_rx_data,
    input  logic [CTRL_WIDTH-1:0]        i_rx_ctrl,
    input  logic                         i_rx_valid,
    output logic [MAX_FRAME_BYTES*8-1:0] o_frame_data,
    output logic [15:0]                  o_frame_len,
    output logic                         o_frame_valid,
    output logic                         o_frame_error,
    output logic                         o_overflow,
    output logic [31:0]                  o_frame_count,
    output logic [1:0]                   o_dbg_state
);

    localparam int BUF_W = MAX_FRAME_BYTES * 8;
    localparam int PTR_W = $clog2(MAX_FRAME_BYTES + 1);

    localparam logic [PTR_W-1:0] MAX_PTR   = PTR_W'(MAX_FRAME_BYTES);
    localparam logic [PTR_W-1:0] FIRST_PTR = PTR_W'(CTRL_WIDTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DROP    = 2'd2;

    // The idle character must be distinguishable from the framing codes.
    // Otherwise, idle padding after TERM could be taken for a frame boundary.
    if (IDLE_CODE == START_CODE || IDLE_CODE == TERM_CODE) begin : g_code_check
        $error("IDLE_CODE collides with START_CODE or TERM_CODE");
    end

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [BUF_W-1:0] out_data_q;
    logic [15:0]      out_len_q, len_d;
    logic [31:0]      count_q;
    logic             valid_q, error_q, ovf_q;

    logic                  frame_done, frame_err, frame_ovf;
    logic                  start_word;
    logic [CTRL_WIDTH-1:0] term_lane;
    logic                  stop, ovf_seen;

    // A start word has control on lane 0 only, and that lane carries START.
    assign start_word = (i_rx_ctrl == CTRL_WIDTH'(1)) &&
                        (i_rx_data[7:0] == START_CODE);

    always_comb begin
        term_lane = '0;
        for (int k = 0; k < CTRL_WIDTH; k++) begin
            term_lane[k] = i_rx_ctrl[k] && (i_rx_data[8*k +: 8] == TERM_CODE);
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        buf_d      = buf_q;
        len_d      = out_len_q;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        frame_ovf  = 1'b0;
        stop       = 1'b0;
        ovf_seen   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_word) begin
                    buf_d                   = '0;
                    buf_d[DATA_WIDTH-1:0]   = i_rx_data;
                    ptr_d                   = FIRST_PTR;
                    state_d                 = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (start_word) begin
                    // Restart wins over anything else in the word.
                    frame_err               = 1'b1;
                    buf_d                   = '0;
                    buf_d[DATA_WIDTH-1:0]   = i_rx_data;
                    ptr_d                   = FIRST_PTR;
                    state_d                 = S_COLLECT;
                end else begin
                    for (int k = 0; k < CTRL_WIDTH; k++) begin
                        if (!stop) begin
                            if (i_rx_ctrl[k] && !term_lane[k]) begin
                                frame_err = 1'b1;
                                state_d   = S_IDLE;
                                stop      = 1'b1;
                            end else if (ptr_d >= MAX_PTR) begin
                                frame_ovf = 1'b1;
                                ovf_seen  = 1'b1;
                                state_d   = S_DROP;
                                stop      = 1'b1;
                            end else begin
                                buf_d[{ptr_d, 3'b000} +: 8] = i_rx_data[8*k +: 8];
                                if (term_lane[k]) begin
                                    len_d      = 16'(ptr_d) + 16'd1;
                                    frame_done = 1'b1;
                                    state_d    = S_IDLE;
                                    stop       = 1'b1;
                                end else begin
                                    ptr_d = ptr_d + 1'b1;
                                end
                            end
                        end else if (ovf_seen && term_lane[k]) begin
                            // The oversize frame ends in the same word where it
                            // overflowed, so there is nothing left to drop.
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            S_DROP: begin
                if (start_word) begin
                    buf_d                   = '0;
                    buf_d[DATA_WIDTH-1:0]   = i_rx_data;
                    ptr_d                   = FIRST_PTR;
                    state_d                 = S_COLLECT;
                end else if (|term_lane) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            buf_q      <= '0;
            out_data_q <= '0;
            out_len_q  <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            ovf_q   <= 1'b0;
            if (i_rx_valid) begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                buf_q   <= buf_d;
                valid_q <= frame_done;
                error_q <= frame_err;
                ovf_q   <= frame_ovf;
                if (frame_done) begin
                    out_data_q <= buf_d;
                    out_len_q  <= len_d;
                    count_q    <= count_q + 32'd1;
                end
            end
        end
    end

    assign o_frame_data  = out_data_q;
    assign o_frame_len   = out_len_q;
    assign o_frame_valid = valid_q;
    assign o_frame_error = error_q;
    assign o_overflow    = ovf_q;
    assign o_frame_count = count_q;
    assign o_dbg_state   = state_q;

endmodule

// File: doc/mac_frame_collector.md
Name: mac_frame_collector

Overview:
- Sits directly upstream of the MAC frame checker.
- Takes a 64-bit/8-lane control+data receive stream (one word per clock, lane 0 first in time) and detects the start control character.
- Packs every frame byte, from START through TERM inclusive, into one flat little-endian byte array.
- Presents that array with a one-cycle valid pulse, a byte length and error flags; the checker consumes the completed frame.

Parameters:
DATA_WIDTH, 64, receive word width (8 lanes of 8 bits)
CTRL_WIDTH, 8, one control flag per lane
MAX_FRAME_BYTES, 1527, capacity in bytes: 8 (start+preamble+SFD) + 1518 + 1 (TERM)
IDLE_CODE, 8'h07, idle control character
START_CODE, 8'hFB, start control character (lane 0 only)
TERM_CODE, 8'hFD, terminate control character (any lane)

Ports:
clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_rx_data  input  DATA_WIDTH  receive word; lane k = i_rx_data[8k+:8]
i_rx_ctrl  input  CTRL_WIDTH  bit k=1: lane k is a control character
i_rx_valid  input  1  word qualifier; word ignored when 0
o_frame_data  output  MAX_FRAME_BYTES*8  frame byte n at [8n+:8]; byte 0 = START_CODE
o_frame_len  output  16  bytes in frame, including START and TERM
o_frame_valid  output  1  one-cycle pulse: o_frame_data and o_frame_len are updated
o_frame_error  output  1  one-cycle pulse: frame aborted (bad control char or restart)
o_overflow  output  1  one-cycle pulse: frame exceeded MAX_FRAME_BYTES
o_frame_count  output  32  count of good frames delivered (wraps at 2^32)

Behaviour:
- Interface:
  - One clock, clk; reset i_rst_n is asynchronous and active-low.
  - All state updates on posedge clk, and only when i_rx_valid=1. Otherwise state, pointer and buffers hold, and pulses deassert.
- Reset values: state IDLE, write pointer 0, working buffer 0, o_frame_data 0, o_frame_len 0, all pulses 0, o_frame_count 0. Reset mid-frame discards the partial frame silently; no pulse is generated.
- Start word: i_rx_ctrl[0]=1, lane0=START_CODE, i_rx_ctrl[7:1]=0.
- FSM states IDLE, COLLECT, DROP:
- IDLE:
  - On a start word: clear the working buffer, write all 8 lanes at bytes 0..7, set pointer=8, go to COLLECT.
  - Every other word (idles, stray data) is ignored.
- COLLECT: scan lanes 0..7 in order.
  - Data lane (ctrl=0): store at the pointer, then increment the pointer.
  - TERM_CODE lane: store it, and set length = pointer+1. Copy the working buffer to o_frame_data and the length to o_frame_len. Pulse o_frame_valid and increment o_frame_count on the next edge, then go to IDLE. Lanes after TERM are ignored.
  - Start word (no TERM seen): pulse o_frame_error, discard the old frame, begin the new frame exactly as from IDLE.
  - Any other control lane (e.g. 8'hFE, or IDLE_CODE before TERM): pulse o_frame_error, go to IDLE. o_frame_data is unchanged.
  - If the next byte to be stored would land at pointer >= MAX_FRAME_BYTES: pulse o_overflow and go to DROP. o_frame_data is unchanged.
- DROP:
  - Discard words until a TERM-containing word, then go to IDLE.
  - A start word in DROP starts a new frame (COLLECT), with no extra pulse.
- Output register:
  - o_frame_data/o_frame_len change only together with o_frame_valid, and hold until the next good frame.
  - Bytes beyond o_frame_len are 0 (the buffer is cleared at start), so a downstream TERM scan is unambiguous.
- Latency: o_frame_valid is asserted one cycle after the edge that sampled the TERM word.
- Pulses are mutually exclusive per cycle. Restart-on-start has priority over everything except reset.

Test Plan:
- Minimum frame, 72 bytes from START to the last FCS byte: word0 = lane0 FB(ctrl) + 55x6 + D5; DA=FFFFFFFFFFFF; SA=123456789ABC; type 002E; 46 payload bytes; 4 FCS bytes; TERM FD in lane 0 of word 9, lanes 1-7 = 07 ctrl. Expected: o_frame_valid one cycle after word 9, o_frame_len=73, byte 72=FD, bytes 73+ = 0, o_frame_count=1.
- TERM in lane 7, then TERM in lane 3, on back-to-back frames. Expected: lengths correct for each; the second frame's o_frame_data has no residue from the first.
- i_rx_valid toggled 0/1 every cycle during a frame. Expected: identical o_frame_data/o_frame_len to the ungated run, with the pulse delayed accordingly.
- 8'hFE control lane in mid-payload. Expected: o_frame_error pulse, o_frame_data unchanged from the previous frame, and the next clean frame is delivered normally.
- A 1600-byte frame. Expected: o_overflow pulses once at byte 1527; no o_frame_valid; the collector returns to IDLE after TERM; the next frame is OK. A second start word mid-frame produces an o_frame_error pulse and the new frame is delivered.
- Assert i_rst_n=0 asynchronously mid-frame. Expected: all outputs 0 immediately; no pulse after release; the next frame gives o_frame_count=1.
